pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Consumes the 2-bit PC-select code from the branch resolution logic and owns the architectural PC.
- Computes the next fetch address, sequences instruction fetch through a req/ack handshake to instruction memory, and presents the fetched instruction to the datapath.
- Detects misaligned control-flow targets and fetch timeouts, and raises a trap for both.
- Sits between the branch/jump decision logic and the instruction memory port.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded when a trap is cleared
- FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before a timeout trap; 0 disables the timeout
- TO_W, 8, width of the timeout counter; must satisfy FETCH_TIMEOUT < 2^TO_W

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pcsrc  in  2  00 = pc+4; 01 = pc+imm (taken branch/jal); 10 = (rs1_data+imm) & ~1 (jalr); 11 = reserved, treated as 00
- imm  in  32  sign-extended immediate of the current instruction
- rs1_data  in  32  rs1 operand for jalr
- commit  in  1  current instruction retires this cycle; pcsrc, imm and rs1_data are valid
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; equals pc while imem_req is high
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr holds a fetched instruction awaiting commit
- instr  out  32  latched instruction
- pc  out  32  PC of instr, or of the in-flight fetch
- pc_plus4  out  32  pc+4, combinational, used as the link value
- trap  out  1  trap pending
- trap_cause  out  2  01 = misaligned target, 10 = fetch timeout, 00 = none
- trap_pc  out  32  offending target (misaligned) or fetch address (timeout)
- trap_clr  in  1  acknowledges the trap

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; pc = RESET_PC; imem_req = 0; instr_valid = 0; instr = 0; trap = 0; trap_cause = 0; trap_pc = 0; timeout counter = 0. Asserting reset mid-fetch drops imem_req immediately.
- IDLE: lasts exactly one cycle after reset release, then goes to FETCH.
- FETCH:
  - imem_req = 1; imem_addr = pc, held stable until ack.
  - Timeout counter increments each cycle without ack.
  - On imem_ack: instr <= imem_rdata; counter cleared; next state EXEC.
  - If FETCH_TIMEOUT != 0 and the counter reaches FETCH_TIMEOUT with no ack: trap = 1, cause = 10, trap_pc = pc, imem_req drops, next state TRAP.
  - An ack arriving in the same cycle the counter reaches the limit wins: no trap.
- EXEC:
  - instr_valid = 1; waits for commit (any number of cycles).
  - On commit, target = pc+4 / pc+imm / (rs1_data+imm) & ~1 per pcsrc.
  - If target passes the alignment check: pc <= target; instr_valid drops next cycle; next state FETCH.
  - If target fails the alignment check (see Optional Feature): trap = 1, cause = 01, trap_pc = target, pc unchanged, next state TRAP.
- TRAP: all outputs hold; imem_req = 0; instr_valid = 0. On trap_clr: pc <= TRAP_VEC, trap and trap_cause cleared, next state FETCH.
- Ignored inputs:
  - imem_ack outside FETCH.
  - commit outside EXEC.
  - trap_clr outside TRAP.
- Arithmetic: all adds are 32-bit modulo 2^32; wrap past 32'hFFFF_FFFC is legal and silent.
- Latency:
  - commit to the next imem_req is 1 cycle.
  - ack to instr_valid is 1 cycle.
  - Best-case throughput is one instruction per 2 cycles when ack and commit arrive immediately.

Optional Feature:
- Macro: PC_SEQ_MISALIGN_TRAP_EN.
- Defined: a target with target[1] = 1 (after the jalr bit-0 clear) causes the misaligned trap in EXEC.
- Undefined:
  - Targets are forced to target & ~3 and never trap.
  - trap_cause 01 is never produced; timeout traps still function.

Test Plan:
- Reset release, imem_ack held high → imem_req rises 1 cycle after release with imem_addr = 0x0; then, with commit held high and pcsrc = 00, successive fetch addresses are 0x0, 0x4, 0x8.
- In EXEC at pc = 0x100, commit with pcsrc = 01, imm = 0xFFFF_FFF0 → next imem_addr = 0xF0. Repeat with pcsrc = 10, rs1_data = 0x2001, imm = 0x10 → imem_addr = 0x2010. Confirm pc_plus4 = 0x104 during the first EXEC.
- Macro defined: pc = 0x40, pcsrc = 01, imm = 0x6 → trap = 1, cause = 01, trap_pc = 0x46, pc stays 0x40. Then trap_clr → imem_addr = 0x100. Macro undefined, same stimulus → imem_addr = 0x44, trap stays 0.
- FETCH_TIMEOUT = 16, imem_ack never asserted → trap rises on the 16th FETCH cycle with cause = 10, trap_pc = current pc, and imem_req drops. Ack on exactly the 16th cycle → no trap, EXEC entered.
- Assert rst_n low while in FETCH and in TRAP → imem_req, instr_valid and trap drop asynchronously, pc = RESET_PC.
- pcsrc = 11 at commit from pc = 0x80 → next fetch at 0x84; commit pulses in FETCH and imem_ack pulses in EXEC produce no state or pc change.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the architectural PC, fetches through a req/ack port and traps on fetch timeouts.
// Define PC_SEQ_MISALIGN_TRAP_EN to trap on targets with bit 1 set; otherwise targets are word-aligned silently.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC      = 32'h0000_0100,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          TO_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc,
    input  logic        trap_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(FETCH_TIMEOUT);
    localparam bit              TO_EN  = (FETCH_TIMEOUT != 0);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic           req_q, req_d;
    logic           valid_q, valid_d;
    logic [31:0]    instr_q, instr_d;
    logic           trap_q, trap_d;
    logic [1:0]     cause_q, cause_d;
    logic [31:0]    tpc_q, tpc_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [TO_W-1:0] cnt_inc;
    logic [31:0]    target_raw;
    logic [31:0]    target;
    logic           misalign;

    assign pc_plus4 = pc_q + 32'd4;
    assign cnt_inc  = cnt_q + TO_W'(1);

    // Candidate next PC; reserved code 11 falls back to sequential flow.
    always_comb begin
        target_raw = pc_plus4;
        case (pcsrc)
            2'b01:   target_raw = pc_q + imm;
            2'b10:   target_raw = (rs1_data + imm) & ~32'd1;
            default: target_raw = pc_plus4;
        endcase
    end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign misalign = target_raw[1];
    assign target   = target_raw;
`else
    assign misalign = 1'b0;
    assign target   = target_raw & ~32'd3;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        valid_d = valid_q;
        instr_d = instr_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        tpc_d   = tpc_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
            S_FETCH: begin
                // An ack in the limit cycle takes priority over the timeout.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end else if (TO_EN && (cnt_inc == TO_LIM)) begin
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    tpc_d   = pc_q;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    valid_d = 1'b0;
                    if (misalign) begin
                        trap_d  = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                        tpc_d   = target;
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = target;
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                if (trap_clr) begin
                    pc_d    = TRAP_VEC;
                    trap_d  = 1'b0;
                    cause_d = CAUSE_NONE;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            tpc_q   <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            tpc_q   <= tpc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign trap_pc     = tpc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: an output-level reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0100;
    localparam int          FT     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic        commit = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc;
    logic        trap_clr = 1'b0;

    int n_vec = 0;
    int n_miss = 0;

    pc_sequencer #(
        .RESET_PC(RST_PC), .TRAP_VEC(TVEC), .FETCH_TIMEOUT(FT), .TO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc), .imm(imm), .rs1_data(rs1_data),
        .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .trap(trap),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_clr(trap_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what each visible output must be, stepping on the clock.
    bit          m_boot  = 1'b1;
    logic [31:0] m_pc    = RST_PC;
    bit          m_req   = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = 32'd0;
    bit          m_trap  = 1'b0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_tpc   = 32'd0;
    int          m_wait  = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] tgt;
        if (!rst_n) begin
            m_boot = 1'b1; m_pc = RST_PC; m_req = 1'b0; m_valid = 1'b0;
            m_instr = 32'd0; m_trap = 1'b0; m_cause = 2'b00; m_tpc = 32'd0; m_wait = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
            m_wait = 0;
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_req = 1'b0; m_valid = 1'b1; m_wait = 0;
            end else begin
                m_wait = m_wait + 1;
                if (FT != 0 && m_wait == FT) begin
                    m_req = 1'b0; m_trap = 1'b1; m_cause = 2'b10; m_tpc = m_pc; m_wait = 0;
                end
            end
        end else if (m_valid) begin
            if (commit) begin
                if (pcsrc == 2'b01)      tgt = m_pc + imm;
                else if (pcsrc == 2'b10) tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
                else                     tgt = m_pc + 32'd4;
                m_valid = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                if (tgt[1]) begin
                    m_trap = 1'b1; m_cause = 2'b01; m_tpc = tgt;
                end else begin
                    m_pc = tgt; m_req = 1'b1;
                end
`else
                m_pc = tgt & 32'hFFFF_FFFC; m_req = 1'b1;
`endif
            end
        end else if (m_trap) begin
            if (trap_clr) begin
                m_pc = TVEC; m_trap = 1'b0; m_cause = 2'b00; m_req = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("addr", imem_addr, m_pc);
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("trap", 32'(trap), 32'(m_trap));
        chk("cause", 32'(trap_cause), 32'(m_cause));
        chk("trap_pc", trap_pc, m_tpc);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL %s: imem_req never rose within 40 cycles", tag);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0013;
        step(2);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("boot_addr", imem_addr, 32'h0);
        commit = 1'b1;
        wait_req("seq1");
        chk("seq_addr4", imem_addr, 32'h4);
        wait_req("seq2");
        chk("seq_addr8", imem_addr, 32'h8);
        imem_ack = 1'b0;
        commit = 1'b0;

        // Timeout: count fetch cycles with req high and no ack
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!imem_req) break;
            n++;
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        chk("to_tpc", trap_pc, 32'h8);
        commit = 1'b1; imem_ack = 1'b1;
        step(2);
        chk("trap_hold", 32'(trap), 32'd1);
        chk("trap_noreq", 32'(imem_req), 32'd0);
        commit = 1'b0; imem_ack = 1'b0;
        trap_clr = 1'b1;
        step(1);
        trap_clr = 1'b0;
        chk("clr_addr", imem_addr, 32'h100);
        chk("clr_trap", 32'(trap), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
        step(1);
        chk("exec_pc", pc, 32'h100);
        chk("link", pc_plus4, 32'h104);
        chk("exec_instr", instr, 32'hDEAD_0001);

        commit = 1'b1; pcsrc = 2'b01; imm = 32'hFFFF_FFF0;
        step(1);
        commit = 1'b0;
        chk("br_addr", imem_addr, 32'hF0);
        step(1);
        commit = 1'b1; pcsrc = 2'b10; rs1_data = 32'h2001; imm = 32'h10;
        step(1);
        commit = 1'b0;
        chk("jalr_addr", imem_addr, 32'h2010);

        // Ack lands in the 16th fetch cycle: no trap
        imem_ack = 1'b0;
        step(15);
        chk("edge_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0016;
        step(1);
        chk("edge_valid", 32'(instr_valid), 32'd1);
        chk("edge_notrap", 32'(trap), 32'd0);
        chk("edge_instr", instr, 32'hCAFE_0016);

        commit = 1'b1; pcsrc = 2'b01; imm = 32'hFFFF_E030;
        step(1);
        commit = 1'b0;
        chk("to40_addr", imem_addr, 32'h40);
        step(1);
        commit = 1'b1; pcsrc = 2'b01; imm = 32'h6;
        step(1);
        commit = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        chk("mis_trap", 32'(trap), 32'd1);
        chk("mis_cause", 32'(trap_cause), 32'd1);
        chk("mis_tpc", trap_pc, 32'h46);
        chk("mis_pc", pc, 32'h40);
        trap_clr = 1'b1;
        step(1);
        trap_clr = 1'b0;
        chk("mis_clr_addr", imem_addr, 32'h100);
`else
        chk("mis_notrap", 32'(trap), 32'd0);
        chk("mis_addr", imem_addr, 32'h44);
`endif
        step(1);
        commit = 1'b1; pcsrc = 2'b01; imm = 32'h80 - m_pc;
        step(1);
        commit = 1'b0;
        chk("to80_addr", imem_addr, 32'h80);
        step(1);
        commit = 1'b1; pcsrc = 2'b11; imm = 32'h1234;
        step(1);
        commit = 1'b0;
        chk("rsvd_addr", imem_addr, 32'h84);

        // Ignored commit in FETCH, ignored ack in EXEC
        imem_ack = 1'b0; commit = 1'b1; pcsrc = 2'b01; imm = 32'h40;
        step(3);
        chk("ign_commit_pc", pc, 32'h84);
        chk("ign_commit_req", 32'(imem_req), 32'd1);
        commit = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0084;
        step(1);
        imem_rdata = 32'h0000_0BAD;
        step(3);
        chk("ign_ack_valid", 32'(instr_valid), 32'd1);
        chk("ign_ack_instr", instr, 32'h0000_0084);
        chk("ign_ack_req", 32'(imem_req), 32'd0);

        // Wrap past the top of the address space
        commit = 1'b1; pcsrc = 2'b01; imm = 32'hFFFF_FF78;
        step(1);
        commit = 1'b0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1);
        commit = 1'b1; pcsrc = 2'b00;
        step(1);
        commit = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset while fetching
        step(1);
        commit = 1'b1; pcsrc = 2'b01; imm = 32'h200;
        step(1);
        commit = 1'b0; imem_ack = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h200);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_f_req", 32'(imem_req), 32'd0);
        chk("arst_f_pc", pc, RST_PC);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("reboot_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        step(1);
        commit = 1'b1; pcsrc = 2'b01; imm = 32'h300;
        step(1);
        commit = 1'b0; imem_ack = 1'b0;
        step(16);
        chk("pre_rst_trap", 32'(trap), 32'd1);
        chk("pre_rst_tpc", trap_pc, 32'h300);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_t_trap", 32'(trap), 32'd0);
        chk("arst_t_cause", 32'(trap_cause), 32'd0);
        chk("arst_t_pc", pc, RST_PC);
        chk("arst_t_valid", 32'(instr_valid), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
